rw_cmd_server: RTL

- Synthesizable server-side executor for the packed read/write command stream that simulation clients push over multisim channels.
- Accepts commands {wdata, address, op} on a valid/ready input, executes them against an internal register-file memory, and queues responses in a response FIFO drained over a valid/ready output.
- Generalises the fixed 64-bit, read/write-only command set to parametrised address/data width, memory depth and response buffering.
- Adds a fetch-and-add op, optional write acknowledges, and error reporting.

---
 rtl/rw_cmd_server.sv | 79 +++++++
 1 files changed

// File: rtl/rw_cmd_server.sv
// rw_cmd_server: executes {wdata, address, op} commands against a register-file memory
// and returns responses in order through a response FIFO.
module rw_cmd_server #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int WRITE_ACK = 1,
  localparam int LW = $clog2(RSP_FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_vld,
  output logic                             cmd_rdy,
  input  logic [DATA_WIDTH+ADDR_WIDTH+63:0] cmd,
  output logic                             rsp_vld,
  input  logic                             rsp_rdy,
  output logic [DATA_WIDTH-1:0]            rsp,
  output logic                             rsp_err,
  output logic [LW-1:0]                    rsp_level
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = RSP_FIFO_DEPTH > 1 ? $clog2(RSP_FIFO_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fd [RSP_FIFO_DEPTH];
  logic                  fe [RSP_FIFO_DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [LW-1:0]         cnt;
  logic                  up;
  logic [63:0]           op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wdata, old, wval, pdata;
  logic                  is_wr, legal, acc, we, push, pop;
  always_comb begin
    op    = cmd[63:0];
    addr  = cmd[64 +: ADDR_WIDTH];
    wdata = cmd[64+ADDR_WIDTH +: DATA_WIDTH];
    idx   = addr[AW-1:0];
    old   = mem[idx];
    is_wr = op == 64'd0;
    legal = addr < ADDR_WIDTH'(DEPTH) && op < 64'd3;
    acc   = cmd_vld && cmd_rdy;
    we    = acc && legal && op != 64'd1;
    wval  = is_wr ? wdata : old + wdata;
    // silent writes only when acks are disabled and the write is legal
    push  = acc && !(legal && is_wr && WRITE_ACK == 0);
    pdata = !legal ? '0 : is_wr ? wdata : old;
    pop   = rsp_vld && rsp_rdy;
  end
  assign rsp_vld   = cnt != '0;
  assign rsp       = rsp_vld ? fd[rp] : '0;
  assign rsp_err   = rsp_vld && fe[rp];
  assign rsp_level = cnt;
  assign cmd_rdy   = up && cnt != LW'(RSP_FIFO_DEPTH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fd[i] <= '0;
        fe[i] <= 1'b0;
      end
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      up  <= 1'b0;
    end else begin
      up <= 1'b1;
      if (we) mem[idx] <= wval;
      if (push) begin
        fd[wp] <= pdata;
        fe[wp] <= !legal;
        wp     <= wp == PW'(RSP_FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(RSP_FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + LW'(push) - LW'(pop);
    end
  end
endmodule
